// File: rtl/lvds_sram_writer.sv
// lvds_sram_writer
//   Fabric-side producer for the HPS-shared on-chip SRAM slave port (s2).
//   Pairs of deserialised LVDS samples are packed into 32-bit words and written
//   into a two-bank ping-pong buffer. Each completed bank is reported through
//   the 6-bit SRAM flag PIO. Capture is gated by the HPS enable PIO.
//
//   Optional build macro: LVDS_SRAM_TEST_PATTERN_EN
//     Adds pattern_sel. While it is high, sample data is replaced by a counter
//     and any valid sample in WAIT_SOF is treated as start of frame.
//
// Ports
//   clk              in   360 MHz PLL clock, single clock domain
//   reset            in   asynchronous, active-high reset
//   en               in   capture enable from HPS PIO (synchronised here)
//   sample_valid     in   sample_data / sample_sof valid this cycle
//   sample_data      in   deserialised LVDS sample
//   sample_sof       in   first sample of a frame
//   pattern_sel      in   (macro only) select counter test pattern
//   sram_address     out  s2 word address
//   sram_chipselect  out  s2 chipselect
//   sram_clken       out  s2 clock enable
//   sram_write       out  s2 write strobe (one cycle per word)
//   sram_writedata   out  packed word {second sample, first sample}
//   sram_byteenable  out  s2 byte enables
//   sram_flag        out  [0] last bank done, [1] done toggle, [5:2] done count
//   overflow         out  sticky: a word completed while a write was still pending
//   fsm_state        out  debug view of the FSM (0 IDLE, 1 WAIT_SOF, 2 WRITE)
//
// Handshake: a sample is taken on every clock where sample_valid is high and
// the FSM is willing to accept it; there is no ready, the source never stalls.
// s2 has zero wait states, so a write strobe is always accepted the cycle it
// is presented.
module lvds_sram_writer #(
    parameter int ADDR_W      = 14,
    parameter int BANK_WORDS  = 8192,
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_sof,
`ifdef LVDS_SRAM_TEST_PATTERN_EN
    input  logic                pattern_sel,
`endif
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_chipselect,
    output logic                sram_clken,
    output logic                sram_write,
    output logic [31:0]         sram_writedata,
    output logic [3:0]          sram_byteenable,
    output logic [5:0]          sram_flag,
    output logic                overflow,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] en_sync_q;
    logic                   en_s;
    logic                   half_q;
    logic [SAMPLE_W-1:0]    low_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W-1:0]      sram_address_q;
    logic                   wr_q;
    logic [31:0]            wdata_q;
    logic                   clken_q;
    logic [5:0]             flag_q;
    logic                   ovf_q;

    logic [SAMPLE_W-1:0]    data_d;
    logic                   sof_d;
    logic                   accept_d;
    logic                   bank_done_d;

    assign en_s = en_sync_q[SYNC_STAGES-1];

`ifdef LVDS_SRAM_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] pat_cnt_q;

    assign data_d = pattern_sel ? pat_cnt_q : sample_data;
    assign sof_d  = pattern_sel | sample_sof;

    // Counter restarts whenever a new capture is armed, so every pattern
    // frame begins at 0 in the low half of address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_cnt_q <= '0;
        end else if (state_q == IDLE && en_s) begin
            pat_cnt_q <= '0;
        end else if (accept_d) begin
            pat_cnt_q <= pat_cnt_q + SAMPLE_W'(1);
        end
    end
`else
    assign data_d = sample_data;
    assign sof_d  = sample_sof;
`endif

    // A sample is consumed on a start-of-frame in WAIT_SOF, or any valid
    // sample in WRITE; samples in the cycle en_s drops are discarded.
    assign accept_d = sample_valid && en_s &&
                      ((state_q == WAIT_SOF && sof_d) || state_q == WRITE);

    // Low ADDR_W-1 bits all ones marks the last word of either bank.
    assign bank_done_d = (sram_address_q[ADDR_W-2:0] == (ADDR_W-1)'(BANK_WORDS-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            en_sync_q      <= '0;
            half_q         <= 1'b0;
            low_q          <= '0;
            addr_q         <= '0;
            sram_address_q <= '0;
            wr_q           <= 1'b0;
            wdata_q        <= '0;
            clken_q        <= 1'b0;
            flag_q         <= '0;
            ovf_q          <= 1'b0;
        end else begin
            clken_q   <= 1'b1;
            en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], en};
            wr_q      <= 1'b0;

            // Flag update trails the strobe of the bank's last word by one
            // cycle and is independent of the FSM, so a write already
            // launched when en_s falls still reports its bank.
            if (wr_q && bank_done_d) begin
                flag_q <= {flag_q[5:2] + 4'd1, ~flag_q[1], sram_address_q[ADDR_W-1]};
            end

            case (state_q)
                IDLE: begin
                    half_q <= 1'b0;
                    addr_q <= '0;
                    if (en_s) begin
                        state_q <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!en_s) begin
                        state_q <= IDLE;
                    end else if (accept_d) begin
                        low_q   <= data_d;
                        half_q  <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (!en_s) begin
                        // Abort: the pending half word is dropped.
                        state_q <= IDLE;
                        half_q  <= 1'b0;
                        addr_q  <= '0;
                    end else if (accept_d) begin
                        if (!half_q) begin
                            low_q  <= data_d;
                            half_q <= 1'b1;
                        end else begin
                            wr_q           <= 1'b1;
                            wdata_q        <= {data_d, low_q};
                            sram_address_q <= addr_q;
                            addr_q         <= addr_q + ADDR_W'(1);
                            half_q         <= 1'b0;
                            // A new word while the previous strobe is still
                            // out would need a second write slot we lack.
                            if (wr_q) begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sram_address    = sram_address_q;
    assign sram_write      = wr_q;
    assign sram_chipselect = wr_q;
    assign sram_byteenable = {4{wr_q}};
    assign sram_writedata  = wdata_q;
    assign sram_clken      = clken_q;
    assign sram_flag       = flag_q;
    assign overflow        = ovf_q;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_lvds_sram_writer.sv
// Directed testbench for lvds_sram_writer.
// Inputs change 1 time unit after the rising edge; outputs are checked at the
// same point (strobes are registered, so they are stable until the next edge).
module tb_lvds_sram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        sample_sof;
    logic [13:0] sram_address;
    logic        sram_chipselect;
    logic        sram_clken;
    logic        sram_write;
    logic [31:0] sram_writedata;
    logic [3:0]  sram_byteenable;
    logic [5:0]  sram_flag;
    logic        overflow;
    logic [1:0]  fsm_state;

    int          total = 0;
    int          bad   = 0;
    int unsigned wr_cnt = 0;
    int unsigned data_err = 0;
    int unsigned base;
    bit          chk_data = 1'b0;

    always #5 clk = ~clk;

    lvds_sram_writer dut (
        .clk             (clk),
        .reset           (reset),
        .en              (en),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .sample_sof      (sample_sof),
`ifdef LVDS_SRAM_TEST_PATTERN_EN
        .pattern_sel     (1'b0),
`endif
        .sram_address    (sram_address),
        .sram_chipselect (sram_chipselect),
        .sram_clken      (sram_clken),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .sram_byteenable (sram_byteenable),
        .sram_flag       (sram_flag),
        .overflow        (overflow),
        .fsm_state       (fsm_state)
    );

    // Write monitor. In the long streams, sample n carries value n and the
    // stream starts at address 0, so word a must be {2a+1, 2a}.
    logic [15:0] e_lo;
    logic [15:0] e_hi;
    always @(negedge clk) begin
        if (sram_write) begin
            wr_cnt++;
            e_lo = 16'(2 * int'(sram_address));
            e_hi = 16'(2 * int'(sram_address) + 1);
            if (chk_data && sram_writedata !== {e_hi, e_lo}) begin
                data_err++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic sof);
        sample_valid = 1'b1;
        sample_data  = d;
        sample_sof   = sof;
        step();
    endtask

    task automatic rearm();
        sample_valid = 1'b0;
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        sample_sof   = 1'b0;
        #2;
        check("rst_clken", 32'(sram_clken), 32'd0);
        check("rst_write", 32'(sram_write), 32'd0);
        check("rst_flag", 32'(sram_flag), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        check("clken_before_edge", 32'(sram_clken), 32'd0);
        step();
        check("clken_after_edge", 32'(sram_clken), 32'd1);

        // Samples with capture disabled must be ignored.
        base = wr_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(16'($urandom_range(0, 65535)), (i == 2));
        end
        sample_valid = 1'b0;
        step();
        check("idle_no_write", wr_cnt - base, 32'd0);
        check("idle_flag", 32'(sram_flag), 32'd0);
        check("idle_state", 32'(fsm_state), 32'd0);

        // First word: a non-sof sample is dropped, then sof 0x1111 + 0x2222.
        en = 1'b1;
        repeat (4) step();
        check("armed_state", 32'(fsm_state), 32'd1);
        base = wr_cnt;
        drive(16'h5555, 1'b0);
        drive(16'h1111, 1'b1);
        check("write_state", 32'(fsm_state), 32'd2);
        drive(16'h2222, 1'b0);
        sample_valid = 1'b0;
        check("w1_write", 32'(sram_write), 32'd1);
        check("w1_cs", 32'(sram_chipselect), 32'd1);
        check("w1_be", 32'(sram_byteenable), 32'hF);
        check("w1_addr", 32'(sram_address), 32'd0);
        check("w1_data", sram_writedata, 32'h22221111);
        step();
        check("w1_count", wr_cnt - base, 32'd1);
        check("w1_width", 32'(sram_write), 32'd0);
        check("w1_be_idle", 32'(sram_byteenable), 32'd0);

        // Bank 0: 16384 samples, 8192 writes.
        rearm();
        base = wr_cnt;
        chk_data = 1'b1;
        for (int i = 0; i < 16384; i++) begin
            drive(16'(i), (i == 0));
        end
        check("b0_last_write", 32'(sram_write), 32'd1);
        check("b0_last_addr", 32'(sram_address), 32'd8191);
        check("b0_flag_before", 32'(sram_flag), 32'd0);
        sample_valid = 1'b0;
        step();
        check("b0_flag", 32'(sram_flag), 32'b000110);
        check("b0_count", wr_cnt - base, 32'd8192);
        check("b0_data", data_err, 32'd0);

        // Bank 1: a stray sof mid-stream must not realign the packing.
        base = wr_cnt;
        for (int i = 16384; i < 32768; i++) begin
            drive(16'(i), (i == 20001));
        end
        check("b1_last_addr", 32'(sram_address), 32'd16383);
        sample_valid = 1'b0;
        step();
        check("b1_flag", 32'(sram_flag), 32'b001001);
        check("b1_count", wr_cnt - base, 32'd8192);
        check("b1_data", data_err, 32'd0);
        chk_data = 1'b0;

        drive(16'hAAAA, 1'b0);
        drive(16'hBBBB, 1'b0);
        sample_valid = 1'b0;
        check("wrap_addr", 32'(sram_address), 32'd0);
        check("wrap_data", sram_writedata, 32'hBBBBAAAA);
        step();
        step();
        check("wrap_flag_hold", 32'(sram_flag), 32'b001001);

        // Abort after 3 samples: one word written, half word discarded.
        rearm();
        base = wr_cnt;
        drive(16'h0A0A, 1'b1);
        drive(16'h0B0B, 1'b0);
        drive(16'h0C0C, 1'b0);
        sample_valid = 1'b0;
        en = 1'b0;
        repeat (4) step();
        check("abort_count", wr_cnt - base, 32'd1);
        check("abort_flag", 32'(sram_flag), 32'b001001);
        check("abort_state", 32'(fsm_state), 32'd0);

        en = 1'b1;
        repeat (4) step();
        base = wr_cnt;
        drive(16'h0D0D, 1'b0);
        drive(16'h0E0E, 1'b0);
        drive(16'h0101, 1'b1);
        drive(16'h0202, 1'b0);
        sample_valid = 1'b0;
        check("rearm_addr", 32'(sram_address), 32'd0);
        check("rearm_data", sram_writedata, 32'h02020101);
        step();
        check("rearm_count", wr_cnt - base, 32'd1);

        // Reset while the word at address 100 is being strobed.
        rearm();
        for (int i = 0; i < 202; i++) begin
            drive(16'(i), (i == 0));
        end
        check("pre_rst_write", 32'(sram_write), 32'd1);
        check("pre_rst_addr", 32'(sram_address), 32'd100);
        #2;
        reset = 1'b1;
        #1;
        check("arst_write", 32'(sram_write), 32'd0);
        check("arst_cs", 32'(sram_chipselect), 32'd0);
        check("arst_be", 32'(sram_byteenable), 32'd0);
        check("arst_addr", 32'(sram_address), 32'd0);
        check("arst_data", sram_writedata, 32'd0);
        check("arst_clken", 32'(sram_clken), 32'd0);
        check("arst_flag", 32'(sram_flag), 32'd0);
        check("arst_state", 32'(fsm_state), 32'd0);
        sample_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        drive(16'h7777, 1'b1);
        drive(16'h8888, 1'b0);
        sample_valid = 1'b0;
        check("post_rst_addr", 32'(sram_address), 32'd0);
        check("post_rst_data", sram_writedata, 32'h88887777);
        step();
        check("overflow", 32'(overflow), 32'd0);
        check("post_rst_flag", 32'(sram_flag), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
